// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory req/gnt/rvalid port between NUM_PORTS
// requesters. Round-robin arbitration, one outstanding transaction, response
// routed back to the owning port. A watchdog turns a missing response into an
// error response after TIMEOUT_CYCLES cycles in WAIT (0 disables it).
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   port_req_i[k]         request from port k
//   port_addr_i[32k+:32]  address of port k
//   port_wdata_i[32k+:32] write data of port k
//   port_we_i[k]          write enable of port k
//   port_be_i[4k+:4]      byte enables of port k
//   port_gnt_o[k]         grant pulse to port k (combinational from mem_gnt_i)
//   port_rvalid_o[k]      response valid to port k (combinational)
//   port_rdata_o          shared response data, 0 when no rvalid bit is set
//   port_error_o          shared response error, 0 when no rvalid bit is set
//   mem_addr_o/wdata_o/we_o/be_o  latched request of the current owner
//   mem_req_o             memory request, high throughout ISSUE
//   mem_rdata_i/gnt_i/rvalid_i/error_i  memory side handshake and response
//   spurious_o            sticky: rvalid seen with no transaction outstanding
module mem_port_arbiter #(
    parameter int unsigned NUM_PORTS      = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_PORTS-1:0]      port_req_i,
    input  logic [NUM_PORTS*32-1:0]   port_addr_i,
    input  logic [NUM_PORTS*32-1:0]   port_wdata_i,
    input  logic [NUM_PORTS-1:0]      port_we_i,
    input  logic [NUM_PORTS*4-1:0]    port_be_i,
    output logic [NUM_PORTS-1:0]      port_gnt_o,
    output logic [NUM_PORTS-1:0]      port_rvalid_o,
    output logic [31:0]               port_rdata_o,
    output logic                      port_error_o,
    output logic [31:0]               mem_addr_o,
    output logic [31:0]               mem_wdata_o,
    output logic                      mem_we_o,
    output logic [3:0]                mem_be_o,
    output logic                      mem_req_o,
    input  logic [31:0]               mem_rdata_i,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic                      mem_error_i,
    output logic                      spurious_o
);

    localparam int unsigned PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [PTR_W-1:0] LAST_PORT  = PTR_W'(NUM_PORTS - 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic              spurious_q, spurious_d;

    logic              win_valid;
    logic [PTR_W-1:0]  win_idx;
    logic [31:0]       scan_idx;
    logic [PTR_W-1:0]  owner_next;

    // Round-robin search: first requester at ptr, ptr+1, ... modulo NUM_PORTS.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        scan_idx  = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            scan_idx = 32'(ptr_q) + i;
            if (scan_idx >= NUM_PORTS) begin
                scan_idx = scan_idx - NUM_PORTS;
            end
            if (!win_valid && port_req_i[scan_idx[PTR_W-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = scan_idx[PTR_W-1:0];
            end
        end
    end

    // Pointer after a completed transaction: the owner drops to lowest priority.
    assign owner_next = (owner_q == LAST_PORT) ? '0 : owner_q + PTR_W'(1);

    // Next-state, latch updates and combinational port-side outputs.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        be_d          = be_q;
        spurious_d    = spurious_q;
        mem_req_o     = 1'b0;
        port_gnt_o    = '0;
        port_rvalid_o = '0;
        port_rdata_o  = '0;
        port_error_o  = 1'b0;

        // A response with nothing outstanding is dropped and flagged.
        if (mem_rvalid_i && (state_q != ST_WAIT)) begin
            spurious_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (win_valid) begin
                    owner_d = win_idx;
                    for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                        if (win_idx == PTR_W'(k)) begin
                            addr_d  = port_addr_i[k*32 +: 32];
                            wdata_d = port_wdata_i[k*32 +: 32];
                            we_d    = port_we_i[k];
                            be_d    = port_be_i[k*4 +: 4];
                        end
                    end
                    state_d = ST_ISSUE;
                end
            end

            ST_ISSUE: begin
                mem_req_o = 1'b1;
                if (mem_gnt_i) begin
                    port_gnt_o[owner_q] = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // A real response wins over a coincident timeout.
                if (mem_rvalid_i) begin
                    port_rvalid_o[owner_q] = 1'b1;
                    port_rdata_o  = mem_rdata_i;
                    port_error_o  = mem_error_i;
                    ptr_d         = owner_next;
                    state_d       = ST_IDLE;
                end else if (TIMEOUT_EN && (cnt_q == CNT_LIMIT)) begin
                    port_rvalid_o[owner_q] = 1'b1;
                    port_error_o  = 1'b1;
                    ptr_d         = owner_next;
                    state_d       = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and latched-request registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            be_q       <= be_d;
            spurious_q <= spurious_d;
        end
    end

    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign mem_we_o    = we_q;
    assign mem_be_o    = be_q;
    assign spurious_o  = spurious_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-port instance with a 4-cycle
// watchdog and a 3-port instance for pointer wrap-around. Inputs change on
// the falling edge; outputs are checked 1 time unit later.
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // 2-port instance
    logic [1:0]  req2, we2, gnt2, rvalid2;
    logic [63:0] addr2, wdata2;
    logic [7:0]  be2;
    logic [31:0] rdata2, maddr2, mwdata2, m_rdata2;
    logic        err2, mwe2, mreq2, m_gnt2, m_rvalid2, m_err2, spur2;
    logic [3:0]  mbe2;

    // 3-port instance
    logic [2:0]  req3, we3, gnt3, rvalid3;
    logic [95:0] addr3, wdata3;
    logic [11:0] be3;
    logic [31:0] rdata3, maddr3, mwdata3, m_rdata3;
    logic        err3, mwe3, mreq3, m_gnt3, m_rvalid3, m_err3, spur3;
    logic [3:0]  mbe3;

    int total = 0;
    int bad   = 0;

    mem_port_arbiter #(.NUM_PORTS(2), .TIMEOUT_CYCLES(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n),
        .port_req_i(req2), .port_addr_i(addr2), .port_wdata_i(wdata2),
        .port_we_i(we2), .port_be_i(be2),
        .port_gnt_o(gnt2), .port_rvalid_o(rvalid2), .port_rdata_o(rdata2),
        .port_error_o(err2),
        .mem_addr_o(maddr2), .mem_wdata_o(mwdata2), .mem_we_o(mwe2),
        .mem_be_o(mbe2), .mem_req_o(mreq2),
        .mem_rdata_i(m_rdata2), .mem_gnt_i(m_gnt2), .mem_rvalid_i(m_rvalid2),
        .mem_error_i(m_err2), .spurious_o(spur2)
    );

    mem_port_arbiter #(.NUM_PORTS(3), .TIMEOUT_CYCLES(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n),
        .port_req_i(req3), .port_addr_i(addr3), .port_wdata_i(wdata3),
        .port_we_i(we3), .port_be_i(be3),
        .port_gnt_o(gnt3), .port_rvalid_o(rvalid3), .port_rdata_o(rdata3),
        .port_error_o(err3),
        .mem_addr_o(maddr3), .mem_wdata_o(mwdata3), .mem_we_o(mwe3),
        .mem_be_o(mbe3), .mem_req_o(mreq3),
        .mem_rdata_i(m_rdata3), .mem_gnt_i(m_gnt3), .mem_rvalid_i(m_rvalid3),
        .mem_error_i(m_err3), .spurious_o(spur3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // All outputs of the 2-port instance must be zero.
    task automatic chk_all_zero(input string tag);
        chk({tag, ".gnt"},    32'(gnt2),    32'h0);
        chk({tag, ".rvalid"}, 32'(rvalid2), 32'h0);
        chk({tag, ".rdata"},  rdata2,       32'h0);
        chk({tag, ".err"},    32'(err2),    32'h0);
        chk({tag, ".maddr"},  maddr2,       32'h0);
        chk({tag, ".mwdata"}, mwdata2,      32'h0);
        chk({tag, ".mwe"},    32'(mwe2),    32'h0);
        chk({tag, ".mbe"},    32'(mbe2),    32'h0);
        chk({tag, ".mreq"},   32'(mreq2),   32'h0);
        chk({tag, ".spur"},   32'(spur2),   32'h0);
    endtask

    initial begin
        rst_n = 1'b0;
        req2 = '0; addr2 = '0; wdata2 = '0; we2 = '0; be2 = '0;
        m_rdata2 = '0; m_gnt2 = 1'b0; m_rvalid2 = 1'b0; m_err2 = 1'b0;
        req3 = '0; addr3 = '0; wdata3 = '0; we3 = '0; be3 = '0;
        m_rdata3 = '0; m_gnt3 = 1'b0; m_rvalid3 = 1'b0; m_err3 = 1'b0;

        // Reset state
        tick(); #1;
        chk_all_zero("reset");
        chk("reset.mreq3", 32'(mreq3), 32'h0);

        // Single read from port 0
        tick(); rst_n = 1'b1;
        req2 = 2'b01; addr2[31:0] = 32'h0000_1040; be2[3:0] = 4'hF;
        #1 chk("rd.idle_mreq", 32'(mreq2), 32'h0);
        tick(); m_gnt2 = 1'b1; #1;
        chk("rd.mreq",  32'(mreq2), 32'h1);
        chk("rd.maddr", maddr2,     32'h0000_1040);
        chk("rd.mwe",   32'(mwe2),  32'h0);
        chk("rd.gnt",   32'(gnt2),  32'h1);
        tick(); m_gnt2 = 1'b0; req2 = 2'b00; #1;
        chk("rd.wait_mreq",   32'(mreq2),   32'h0);
        chk("rd.wait_rvalid", 32'(rvalid2), 32'h0);
        tick(); m_rvalid2 = 1'b1; m_rdata2 = 32'hDEAD_BEEF; #1;
        chk("rd.rvalid", 32'(rvalid2), 32'h1);
        chk("rd.rdata",  rdata2,       32'hDEAD_BEEF);
        chk("rd.err",    32'(err2),    32'h0);
        tick(); m_rvalid2 = 1'b0; #1;
        chk("rd.after_rvalid", 32'(rvalid2), 32'h0);
        chk("rd.after_rdata",  rdata2,       32'h0);
        chk("rd.spur",         32'(spur2),   32'h0);

        // Round-robin fairness from reset: order 0,1,0,1
        tick(); rst_n = 1'b0; #1;
        tick(); rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); req2 = 2'b11; m_rvalid2 = 1'b0; #1;
            chk("rr.idle_mreq", 32'(mreq2), 32'h0);
            tick(); m_gnt2 = 1'b1; #1;
            chk("rr.gnt", 32'(gnt2), (k % 2 == 1) ? 32'h2 : 32'h1);
            tick(); m_gnt2 = 1'b0; m_rvalid2 = 1'b1; m_rdata2 = 32'(k + 100); #1;
            chk("rr.rvalid", 32'(rvalid2), (k % 2 == 1) ? 32'h2 : 32'h1);
            chk("rr.rdata",  rdata2,       32'(k + 100));
        end
        tick(); m_rvalid2 = 1'b0; req2 = 2'b00; #1;
        chk("rr.end_mreq", 32'(mreq2), 32'h0);

        // Grant stall on port 1 with changing inputs
        tick(); req2 = 2'b10; addr2[63:32] = 32'hA000_0010; wdata2[63:32] = 32'h1111_2222;
        we2 = 2'b10; be2[7:4] = 4'hC; #1;
        for (int i = 0; i < 5; i++) begin
            tick();
            addr2[63:32]  = 32'hBAD0_0000 + 32'(i);
            wdata2[63:32] = 32'h5A5A_0000 + 32'(i);
            if (i == 2) req2 = 2'b00;
            #1;
            chk("stall.mreq",   32'(mreq2), 32'h1);
            chk("stall.maddr",  maddr2,     32'hA000_0010);
            chk("stall.mwdata", mwdata2,    32'h1111_2222);
            chk("stall.mwe",    32'(mwe2),  32'h1);
            chk("stall.mbe",    32'(mbe2),  32'hC);
            chk("stall.gnt",    32'(gnt2),  32'h0);
        end
        tick(); m_gnt2 = 1'b1; #1;
        chk("stall.gnt_pulse", 32'(gnt2), 32'h2);
        tick(); m_gnt2 = 1'b0; m_rvalid2 = 1'b1; m_rdata2 = 32'hCAFE_F00D; m_err2 = 1'b1; #1;
        chk("stall.gnt_after", 32'(gnt2),    32'h0);
        chk("stall.rvalid",    32'(rvalid2), 32'h2);
        chk("stall.rdata",     rdata2,       32'hCAFE_F00D);
        chk("stall.err",       32'(err2),    32'h1);
        tick(); m_rvalid2 = 1'b0; m_err2 = 1'b0; we2 = 2'b00; #1;
        chk("stall.idle_err", 32'(err2), 32'h0);

        // Watchdog: 4 silent WAIT cycles, then a forced error response
        tick(); req2 = 2'b01; addr2[31:0] = 32'h0000_2000; m_rdata2 = 32'h5555_5555; #1;
        tick(); m_gnt2 = 1'b1; #1;
        chk("wd.gnt", 32'(gnt2), 32'h1);
        tick(); m_gnt2 = 1'b0; req2 = 2'b00; #1;
        chk("wd.wait0", 32'(rvalid2), 32'h0);
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            chk("wd.wait", 32'(rvalid2), 32'h0);
        end
        tick(); #1;
        chk("wd.rvalid", 32'(rvalid2), 32'h1);
        chk("wd.err",    32'(err2),    32'h1);
        chk("wd.rdata",  rdata2,       32'h0);
        tick(); m_rvalid2 = 1'b1; m_rdata2 = 32'h7777_7777; #1;
        chk("wd.late_rvalid", 32'(rvalid2), 32'h0);
        chk("wd.late_rdata",  rdata2,       32'h0);
        chk("wd.spur_before", 32'(spur2),   32'h0);
        tick(); m_rvalid2 = 1'b0; #1;
        chk("wd.spur", 32'(spur2), 32'h1);

        // Real rvalid coincident with the timeout is forwarded unchanged
        tick(); req2 = 2'b01; #1;
        tick(); m_gnt2 = 1'b1; #1;
        chk("co.gnt", 32'(gnt2), 32'h1);
        tick(); m_gnt2 = 1'b0; req2 = 2'b00; #1;
        for (int i = 1; i < 4; i++) begin
            tick(); #1;
            chk("co.wait", 32'(rvalid2), 32'h0);
        end
        tick(); m_rvalid2 = 1'b1; m_rdata2 = 32'h1234_5678; m_err2 = 1'b0; #1;
        chk("co.rvalid", 32'(rvalid2), 32'h1);
        chk("co.rdata",  rdata2,       32'h1234_5678);
        chk("co.err",    32'(err2),    32'h0);
        tick(); m_rvalid2 = 1'b0; #1;

        // Reset during WAIT; pointer was 1 before the reset
        tick(); req2 = 2'b01; #1;
        tick(); m_gnt2 = 1'b1; #1;
        tick(); m_gnt2 = 1'b0; req2 = 2'b00; #1;
        chk("rst.wait_mreq", 32'(mreq2), 32'h0);
        tick(); rst_n = 1'b0; m_gnt2 = 1'b1; #1;
        chk_all_zero("rst.during");
        tick(); rst_n = 1'b1; m_gnt2 = 1'b0; m_rvalid2 = 1'b1; m_rdata2 = 32'h9999_9999; #1;
        chk("rst.late_rvalid", 32'(rvalid2), 32'h0);
        chk("rst.late_rdata",  rdata2,       32'h0);
        tick(); m_rvalid2 = 1'b0; req2 = 2'b11; #1;
        chk("rst.spur", 32'(spur2), 32'h1);
        tick(); m_gnt2 = 1'b1; #1;
        chk("rst.ptr0_gnt", 32'(gnt2), 32'h1);
        tick(); m_gnt2 = 1'b0; req2 = 2'b00; m_rvalid2 = 1'b1; #1;
        chk("rst.rvalid", 32'(rvalid2), 32'h1);
        tick(); m_rvalid2 = 1'b0; #1;

        // NUM_PORTS=3: drive ptr to 2, then ports 0 and 1 request
        tick(); req3 = 3'b010; #1;
        tick(); m_gnt3 = 1'b1; #1;
        chk("w3.setup_gnt", 32'(gnt3), 32'h2);
        tick(); m_gnt3 = 1'b0; req3 = 3'b000; m_rvalid3 = 1'b1; #1;
        chk("w3.setup_rvalid", 32'(rvalid3), 32'h2);
        tick(); m_rvalid3 = 1'b0; req3 = 3'b011; #1;
        chk("w3.idle_mreq", 32'(mreq3), 32'h0);
        tick(); m_gnt3 = 1'b1; #1;
        chk("w3.first_gnt", 32'(gnt3), 32'h1);
        tick(); m_gnt3 = 1'b0; m_rvalid3 = 1'b1; #1;
        chk("w3.first_rvalid", 32'(rvalid3), 32'h1);
        tick(); m_rvalid3 = 1'b0; #1;
        tick(); m_gnt3 = 1'b1; #1;
        chk("w3.second_gnt", 32'(gnt3), 32'h2);
        tick(); m_gnt3 = 1'b0; m_rvalid3 = 1'b1; req3 = 3'b000; #1;
        chk("w3.second_rvalid", 32'(rvalid3), 32'h2);
        tick(); m_rvalid3 = 1'b0; #1;
        chk("w3.spur", 32'(spur3), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
